// File: rtl/fp32_arith_unit.sv
// fp32_arith_unit: IEEE-754 binary32 add/sub/mul/div behind a start/finish handshake.
// One operation in flight: IDLE -> UNPACK -> CALC -> NORM -> DONE.
// CALC takes one clock for add/sub/mul. For div it takes DIV_ITERS clocks (restoring, 1 bit/clock).
// Optional feature macro: ROUND_NEAREST_EN selects round-to-nearest-even.
// Without it, results are truncated (round toward zero).
module fp32_arith_unit #(
  parameter int DIV_ITERS = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  funct,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] o,
  output logic        finish,
  output logic        busy,
  output logic        zero,
  output logic        ovf,
  output logic        unf
);

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_CALC, S_NORM, S_DONE} state_e;
  typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_DIV = 2'd2, OP_MUL = 2'd3} op_e;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [30:0] INF_MAG = 31'h7F80_0000;
  localparam int          CNT_W   = (DIV_ITERS > 1) ? $clog2(DIV_ITERS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITERS - 1);

  state_e state_q, state_d;
  op_e    op_q;
  logic   accept;

  logic [31:0] a_q, b_q;
  logic [CNT_W-1:0] cnt_q;
  logic [24:0] r_q;
  logic [DIV_ITERS-1:0] q_q;
  logic [27:0] mant_q;
  logic signed [9:0] exp_q;
  logic sign_q;
  logic spec_hit_q, spec_zero_q, spec_ovf_q;
  logic [31:0] spec_o_q;

  // Unpacked operand fields (exp == 0 is treated as zero, so denormals never reach the datapath)
  logic sa, sb, sbe, sx;
  logic [7:0] ea, eb;
  logic [23:0] ma, mb;
  logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

  assign accept = (state_q == S_IDLE) && start && !busy;

  // Split operands into sign/exponent/mantissa with hidden bit and classify them
  always_comb begin
    sa     = a_q[31];
    sb     = b_q[31];
    ea     = a_q[30:23];
    eb     = b_q[30:23];
    ma     = {ea != 8'd0, a_q[22:0]};
    mb     = {eb != 8'd0, b_q[22:0]};
    a_zero = (ea == 8'd0);
    b_zero = (eb == 8'd0);
    a_inf  = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
    b_inf  = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
    a_nan  = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
    b_nan  = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
    sbe    = sb ^ (op_q == OP_SUB);
    sx     = sa ^ sb;
  end

  // Special operand combinations that bypass the arithmetic path
  logic spec_hit, spec_zero, spec_ovf;
  logic [31:0] spec_o;
  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    spec_hit  = 1'b0;
    spec_o    = 32'd0;
    spec_zero = 1'b0;
    spec_ovf  = 1'b0;
    if (a_nan || b_nan) begin
      spec_hit = 1'b1;
      spec_o   = QNAN;
    end else begin
      case (op_q)
        OP_ADD, OP_SUB: begin
          if (a_inf && b_inf) begin
            spec_hit = 1'b1;
            spec_o   = (sa == sbe) ? {sa, INF_MAG} : QNAN;
          end else if (a_inf) begin
            spec_hit = 1'b1;
            spec_o   = {sa, INF_MAG};
          end else if (b_inf) begin
            spec_hit = 1'b1;
            spec_o   = {sbe, INF_MAG};
          end else if (a_zero && b_zero) begin
            spec_hit  = 1'b1;
            spec_o    = {sa & sbe, 31'd0};
            spec_zero = 1'b1;
          end else if (a_zero) begin
            spec_hit = 1'b1;
            spec_o   = {sbe, b_q[30:0]};
          end else if (b_zero) begin
            spec_hit = 1'b1;
            spec_o   = a_q;
          end
        end
        OP_MUL: begin
          if ((a_inf && b_zero) || (a_zero && b_inf)) begin
            spec_hit = 1'b1;
            spec_o   = QNAN;
          end else if (a_inf || b_inf) begin
            spec_hit = 1'b1;
            spec_o   = {sx, INF_MAG};
          end else if (a_zero || b_zero) begin
            spec_hit  = 1'b1;
            spec_o    = {sx, 31'd0};
            spec_zero = 1'b1;
          end
        end
        default: begin
          if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_hit = 1'b1;
            spec_o   = QNAN;
          end else if (a_inf) begin
            spec_hit = 1'b1;
            spec_o   = {sx, INF_MAG};
          end else if (b_inf) begin
            spec_hit  = 1'b1;
            spec_o    = {sx, 31'd0};
            spec_zero = 1'b1;
          end else if (b_zero) begin
            spec_hit = 1'b1;
            spec_o   = {sx, INF_MAG};
            spec_ovf = 1'b1;
          end else if (a_zero) begin
            spec_hit  = 1'b1;
            spec_o    = {sx, 31'd0};
            spec_zero = 1'b1;
          end
        end
      endcase
    end
  end

  // Single-cycle add/sub/mul datapath, plus divider setup.
  // Layout of calc_mant: bit 27 is the carry, bit 26 is the hidden bit, bits 2:0 are guard/round/sticky.
  logic swap, ma_lt, lost, sl, ss;
  logic [7:0] el, es, d;
  logic [23:0] ml, ms;
  logic [4:0] dcap;
  logic [26:0] al_s, shifted, mask;
  logic [27:0] sum, calc_mant;
  logic [47:0] prod;
  logic signed [9:0] calc_exp;
  logic calc_sign;
  logic [24:0] div_r_init;
  always_comb begin
    swap    = {eb, mb} > {ea, ma};
    el      = swap ? eb : ea;
    es      = swap ? ea : eb;
    ml      = swap ? mb : ma;
    ms      = swap ? ma : mb;
    sl      = swap ? sbe : sa;
    ss      = swap ? sa : sbe;
    d       = el - es;
    dcap    = (d > 8'd27) ? 5'd27 : d[4:0];
    al_s    = {ms, 3'b000};
    shifted = al_s >> dcap;
    mask    = ~(27'h7FF_FFFF << dcap);
    lost    = |(al_s & mask);
    if (sl == ss)
      sum = {1'b0, ml, 3'b000} + {1'b0, shifted[26:1], shifted[0] | lost};
    else
      sum = {1'b0, ml, 3'b000} - {1'b0, shifted[26:1], shifted[0] | lost};
    prod  = 48'(ma) * 48'(mb);
    ma_lt = ma < mb;
    // Pre-scale the dividend when it is smaller, so the quotient always lands in [1,2)
    div_r_init = ma_lt ? {ma, 1'b0} : {1'b0, ma};
    calc_mant  = 28'd0;
    calc_exp   = 10'sd0;
    calc_sign  = sx;
    case (op_q)
      OP_ADD, OP_SUB: begin
        calc_mant = sum;
        calc_exp  = $signed({2'b00, el});
        calc_sign = sl;
      end
      OP_MUL: begin
        calc_mant = {prod[47:21], |prod[20:0]};
        calc_exp  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
      end
      default: begin
        calc_exp = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127
                   - $signed({9'd0, ma_lt});
      end
    endcase
  end

  // One restoring-division step: subtract the divisor when it fits, shift in the quotient bit
  logic r_ge;
  logic [24:0] r_sub, r_next;
  logic [DIV_ITERS-1:0] q_next;
  always_comb begin
    r_ge   = r_q >= {1'b0, mb};
    r_sub  = r_ge ? (r_q - {1'b0, mb}) : r_q;
    r_next = {r_sub[23:0], 1'b0};
    q_next = {q_q[DIV_ITERS-2:0], r_ge};
  end

  // Normalise (right by one on carry, else leading-zero left shift), round, and pack
  logic [27:0] in_m;
  logic [26:0] nm;
  logic [4:0] lz;
  logic found;
  logic signed [9:0] ne, fe;
  logic [22:0] frac;
  logic [31:0] res_o;
  logic res_zero, res_ovf, res_unf;
`ifdef ROUND_NEAREST_EN
  logic rnd_inc;
  logic [24:0] rm;
`endif
  always_comb begin
    // Divider remainder supplies the guard bit; a nonzero leftover remainder supplies the sticky bit
    in_m  = (op_q == OP_DIV) ? {1'b0, q_q[DIV_ITERS-1 -: 24], r_ge, 1'b0, |r_sub} : mant_q;
    lz    = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found) begin
        if (in_m[i]) found = 1'b1;
        else         lz    = lz + 5'd1;
      end
    end
    if (in_m[27]) begin
      nm = {in_m[27:2], in_m[1] | in_m[0]};
      ne = exp_q + 10'sd1;
    end else begin
      nm = in_m[26:0] << lz;
      ne = exp_q - $signed({5'd0, lz});
    end
`ifdef ROUND_NEAREST_EN
    rnd_inc = nm[2] & (nm[1] | nm[0] | nm[3]);
    rm      = {1'b0, nm[26:3]} + {24'd0, rnd_inc};
    if (rm[24]) begin
      frac = rm[23:1];
      fe   = ne + 10'sd1;
    end else begin
      frac = rm[22:0];
      fe   = ne;
    end
`else
    frac = nm[25:3];
    fe   = ne;
`endif
    res_o    = {sign_q, fe[7:0], frac};
    res_zero = 1'b0;
    res_ovf  = 1'b0;
    res_unf  = 1'b0;
    if (spec_hit_q) begin
      res_o    = spec_o_q;
      res_zero = spec_zero_q;
      res_ovf  = spec_ovf_q;
    end else if (nm == 27'd0) begin
      res_o    = 32'd0;
      res_zero = 1'b1;
    end else if (fe >= 10'sd255) begin
      res_o   = {sign_q, INF_MAG};
      res_ovf = 1'b1;
    end else if (fe <= 10'sd0) begin
      res_o    = {sign_q, 31'd0};
      res_zero = 1'b1;
      res_unf  = 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_UNPACK;
      S_UNPACK: state_d = S_CALC;
      S_CALC:   if (op_q != OP_DIV || cnt_q == CNT_LAST) state_d = S_NORM;
      S_NORM:   state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Visible outputs: result and flags load in NORM, finish pulses the cycle after DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o      <= 32'd0;
      finish <= 1'b0;
      busy   <= 1'b0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      finish <= (state_q == S_DONE);
      if (accept)      busy <= 1'b1;
      else if (finish) busy <= 1'b0;
      if (state_q == S_NORM) begin
        o    <= res_o;
        zero <= res_zero;
        ovf  <= res_ovf;
        unf  <= res_unf;
      end
    end
  end

  // Operand and working registers
  // NOTE: datapath registers are left unreset; control only reads them after loading them.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= a;
      b_q  <= b;
      op_q <= op_e'(funct);
    end
    case (state_q)
      S_UNPACK: begin
        spec_hit_q  <= spec_hit;
        spec_o_q    <= spec_o;
        spec_zero_q <= spec_zero;
        spec_ovf_q  <= spec_ovf;
        r_q         <= div_r_init;
        q_q         <= '0;
        cnt_q       <= '0;
      end
      S_CALC: begin
        mant_q <= calc_mant;
        exp_q  <= calc_exp;
        sign_q <= calc_sign;
        if (op_q == OP_DIV) begin
          r_q   <= r_next;
          q_q   <= q_next;
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fp32_arith_unit.sv
// Directed self-checking bench for fp32_arith_unit: result, flags and latency for each operation,
// special operands, start-while-busy rejection, and reset in the middle of a division.
module tb_fp32_arith_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  funct = 2'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [31:0] o;
  logic        finish, busy, zero, ovf, unf;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    logic [1:0]  f;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] eo;
    logic [2:0]  ef;   // {zero, ovf, unf}
    int          el;
  } vec_t;

  fp32_arith_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct(funct), .a(a), .b(b),
    .o(o), .finish(finish), .busy(busy), .zero(zero), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  // Launch one operation and wait (bounded) for finish; lat counts clocks from the accepting edge
  task automatic run_op(input logic [1:0] f, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output logic [2:0] flg, output int lat);
    @(negedge clk);
    funct = f; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (finish !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = o;
    flg = {zero, ovf, unf};
    if (finish !== 1'b1) begin
      tests++; fails++;
      $display("FAIL timeout f=%0d a=%h b=%h: no finish within %0d clocks", f, x, y, lat);
    end
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if ({o, finish, busy, zero, ovf, unf} !== 37'd0) begin
      fails++;
      $display("FAIL reset_state o=%h finish=%b busy=%b flags=%b%b%b, expected all zero",
               o, finish, busy, zero, ovf, unf);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_sub();
    vec_t v [3];
    logic [31:0] r; logic [2:0] fl; int lat;
    v[0] = '{"add_1p5_2p25", 2'd0, 32'h3FC00000, 32'h40100000, 32'h40700000, 3'b000, 4};
    v[1] = '{"sub_1_1p5",    2'd1, 32'h3F800000, 32'h3FC00000, 32'hBF000000, 3'b000, 4};
    v[2] = '{"sub_cancel",   2'd1, 32'h40700000, 32'h40700000, 32'h00000000, 3'b100, 4};
    for (int i = 0; i < 3; i++) begin
      run_op(v[i].f, v[i].x, v[i].y, r, fl, lat);
      tests++;
      if ({r, fl} !== {v[i].eo, v[i].ef}) begin
        fails++;
        $display("FAIL %s o=%h flags=%b expected o=%h flags=%b", v[i].name, r, fl, v[i].eo, v[i].ef);
      end
      tests++;
      if (lat !== v[i].el) begin
        fails++;
        $display("FAIL %s_latency got %0d expected %0d", v[i].name, lat, v[i].el);
      end
    end
  endtask

  task automatic test_mul();
    vec_t v [3];
    logic [31:0] r; logic [2:0] fl; int lat;
    v[0] = '{"mul_3_m2",  2'd3, 32'h40400000, 32'hC0000000, 32'hC0C00000, 3'b000, 4};
    v[1] = '{"mul_ovf",   2'd3, 32'h7F000000, 32'h40000000, 32'h7F800000, 3'b010, 4};
    v[2] = '{"mul_unf",   2'd3, 32'h00800000, 32'h00800000, 32'h00000000, 3'b101, 4};
    for (int i = 0; i < 3; i++) begin
      run_op(v[i].f, v[i].x, v[i].y, r, fl, lat);
      tests++;
      if ({r, fl} !== {v[i].eo, v[i].ef}) begin
        fails++;
        $display("FAIL %s o=%h flags=%b expected o=%h flags=%b", v[i].name, r, fl, v[i].eo, v[i].ef);
      end
      tests++;
      if (lat !== v[i].el) begin
        fails++;
        $display("FAIL %s_latency got %0d expected %0d", v[i].name, lat, v[i].el);
      end
    end
  endtask

  task automatic test_div();
    vec_t v [4];
    logic [31:0] r; logic [2:0] fl; int lat;
    v[0] = '{"div_6_1p5",  2'd2, 32'h40C00000, 32'h3FC00000, 32'h40800000, 3'b000, 27};
    v[1] = '{"div_by_0",   2'd2, 32'h3F800000, 32'h00000000, 32'h7F800000, 3'b010, 27};
`ifdef ROUND_NEAREST_EN
    v[2] = '{"div_1_3",    2'd2, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 3'b000, 27};
`else
    v[2] = '{"div_1_3",    2'd2, 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 3'b000, 27};
`endif
    v[3] = '{"div_by_inf", 2'd2, 32'hBF800000, 32'h7F800000, 32'h80000000, 3'b100, 27};
    for (int i = 0; i < 4; i++) begin
      run_op(v[i].f, v[i].x, v[i].y, r, fl, lat);
      tests++;
      if ({r, fl} !== {v[i].eo, v[i].ef}) begin
        fails++;
        $display("FAIL %s o=%h flags=%b expected o=%h flags=%b", v[i].name, r, fl, v[i].eo, v[i].ef);
      end
      tests++;
      if (lat !== v[i].el) begin
        fails++;
        $display("FAIL %s_latency got %0d expected %0d", v[i].name, lat, v[i].el);
      end
    end
  endtask

  task automatic test_special();
    vec_t v [4];
    logic [31:0] r; logic [2:0] fl; int lat;
    v[0] = '{"nan_add",   2'd0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b000, 4};
    v[1] = '{"inf_m_inf", 2'd1, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 3'b000, 4};
    v[2] = '{"zero_x_inf",2'd3, 32'h00000000, 32'hFF800000, 32'h7FC00000, 3'b000, 4};
    v[3] = '{"inf_x_2",   2'd3, 32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000, 4};
    for (int i = 0; i < 4; i++) begin
      run_op(v[i].f, v[i].x, v[i].y, r, fl, lat);
      tests++;
      if ({r, fl} !== {v[i].eo, v[i].ef}) begin
        fails++;
        $display("FAIL %s o=%h flags=%b expected o=%h flags=%b", v[i].name, r, fl, v[i].eo, v[i].ef);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int extra;
    @(negedge clk);
    funct = 2'd0; a = 32'h3FC00000; b = 32'h40100000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    @(negedge clk); lat++;
    funct = 2'd3; a = 32'h7F000000; b = 32'h40000000; start = 1'b1;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_busy got %b expected 1", busy);
    end
    @(negedge clk); lat++;
    start = 1'b0;
    while (finish !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    tests++;
    if ({o, zero, ovf, unf, finish} !== {32'h40700000, 3'b000, 1'b1} || lat !== 4) begin
      fails++;
      $display("FAIL b2b_result o=%h flags=%b%b%b finish=%b lat=%0d expected o=40700000 flags=000 finish=1 lat=4",
               o, zero, ovf, unf, finish, lat);
    end
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (finish === 1'b1) extra++;
    end
    tests++;
    if (extra !== 0 || busy !== 1'b0 || o !== 32'h40700000) begin
      fails++;
      $display("FAIL b2b_single_finish extra=%0d busy=%b o=%h expected 0, 0, 40700000", extra, busy, o);
    end
  endtask

  task automatic test_reset_mid_div();
    logic [31:0] r; logic [2:0] fl; int lat;
    int seen;
    @(negedge clk);
    funct = 2'd2; a = 32'h40C00000; b = 32'h3FC00000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({o, busy, finish, zero, ovf, unf} !== 37'd0) begin
      fails++;
      $display("FAIL rst_mid_div o=%h busy=%b finish=%b flags=%b%b%b expected all zero",
               o, busy, finish, zero, ovf, unf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (finish === 1'b1 || busy === 1'b1) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL rst_no_finish saw finish/busy in %0d cycles, expected 0", seen);
    end
    run_op(2'd0, 32'h3FC00000, 32'h40100000, r, fl, lat);
    tests++;
    if ({r, fl} !== {32'h40700000, 3'b000} || lat !== 4) begin
      fails++;
      $display("FAIL rst_then_add o=%h flags=%b lat=%0d expected 40700000 000 4", r, fl, lat);
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mul();
    test_div();
    test_special();
    test_back_to_back();
    test_reset_mid_div();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
